pkt_ingress_dispatch: RTL
=========================

Name: pkt_ingress_dispatch

Overview:
Ingress stage directly upstream of the per-priority packet FIFOs. Receives one packet stream (sop/eop/vld + 256-bit beats) and reads a 3-bit priority from the header beat. Steers whole packets to one of NUM_PRI FIFO write ports. Enforces packet framing, drops packets whose target queue cannot take a maximum-size packet, and counts drops and framing errors.

Parameters:
DATA_W, 256, beat width; matches FIFO data width
NUM_PRI, 8, number of priority queues
PRI_W, 3, priority field width (clog2 of NUM_PRI)
PRI_LSB, 0, bit position of the priority field in the sop beat
MAX_BEATS, 64, maximum legal packet length in beats
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_sop  in  1  first beat of packet
in_eop  in  1  last beat of packet
in_vld  in  1  beat valid; no backpressure to the source
in_data  in  DATA_W  beat payload
q_full  in  NUM_PRI  per-queue flag: cannot accept MAX_BEATS more beats
q_wr_vld  out  NUM_PRI  one-hot write strobe to the selected queue
q_wr_sop  out  1  shared sop to the queues
q_wr_eop  out  1  shared eop to the queues
q_wr_data  out  DATA_W  shared data to the queues
drop_cnt  out  CNT_W  packets dropped because the queue was full; saturating
err_cnt  out  CNT_W  framing/length errors; saturating
busy  out  1  high when state is not IDLE

Behaviour:
- All outputs registered. Reset value of every output is 0. Reset forces state to IDLE and clears the current priority and beat_cnt.
- Latency is exactly 1 cycle from an accepted input beat to the matching q_wr_* beat. On a cycle with nothing to forward, q_wr_vld is 0 (sop, eop and data are don't-care; driven 0).
- State machine has three states: IDLE, FWD, DROP. Internal registers: cur_pri (PRI_W bits) and beat_cnt (clog2(MAX_BEATS)+1 bits).
- IDLE, in_vld and in_sop:
  - pri = in_data[PRI_LSB +: PRI_W].
  - If q_full[pri] is 1: drop the packet and increment drop_cnt. Stay in IDLE if in_eop, otherwise go to DROP.
  - Otherwise: forward the beat with q_wr_sop=1, q_wr_eop=in_eop, q_wr_vld=onehot(pri). Set cur_pri=pri and beat_cnt=1. Stay in IDLE if in_eop, otherwise go to FWD.
- IDLE, in_vld without in_sop: orphan beat. Discard it and increment err_cnt. A beat with sop=0 and eop=1 is treated the same way.
- FWD, in_vld without in_sop:
  - Forward to cur_pri and increment beat_cnt.
  - If in_eop: forward with eop and go to IDLE.
  - Else if beat_cnt+1 equals MAX_BEATS: force q_wr_eop=1 on this beat, increment err_cnt, go to DROP.
- FWD, in_vld with in_sop (stray sop):
  - Write this beat to cur_pri with sop=0, eop=1 to close the open packet.
  - Increment err_cnt.
  - The new packet is discarded: go to DROP, or to IDLE if in_eop.
- DROP, in_vld:
  - Discard beats until in_eop, then go to IDLE.
  - A beat with in_sop is re-evaluated as in IDLE in the same cycle (framing recovery); no err_cnt increment.
- No in_vld: state holds. q_full is sampled only at sop; a queue going full mid-packet does not affect the packet in flight.
- Counters saturate at all-ones. drop_cnt and err_cnt never both increment on the same beat, except in the DROP re-sop case, where only drop_cnt can increment.
- Reset mid-packet: the downstream packet is left unterminated; the FIFO stage is reset by the same rst. After reset, body beats count as orphans.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, FWD, DROP);
  - default DATA_W=256, NUM_PRI=8, PRI_W=3;
  - the onehot-of-priority function.
- One natural sub-module: sat_counter (parameter CNT_W; inputs inc and rst), instantiated twice for drop_cnt and err_cnt.

Test Plan:
- 3-beat packet, pri=5, q_full=0 → q_wr_vld=8'h20 on cycles t+1..t+3; sop on beat 1, eop on beat 3; data equal to input; counters 0.
- 1-beat packet (sop=eop=1), pri=0 → one write, q_wr_vld=8'h01, sop=eop=1; busy stays 0.
- sop with pri=2 while q_full[2]=1, 4 beats → no q_wr_vld; drop_cnt=1. An immediately following pri=3 packet is forwarded normally.
- MAX_BEATS=4, 6-beat packet pri=1 → beats 1-4 written, beat 4 with eop=1; beats 5-6 dropped; err_cnt=1; IDLE after beat 6.
- Stray sop at beat 3 of pri=6 packet, new header pri=4 → beat 3 written to q6 with eop=1, err_cnt=1, rest dropped. A sop arriving while in DROP is forwarded to its queue.
- rst asserted mid-packet for one cycle → all outputs 0 the next cycle. The following 2 body beats raise err_cnt to 2. Counters saturate at 16'hFFFF under repeated drops.

Source files
------------

// File: rtl/pkt_ingress_dispatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_ingress_dispatch_pkg: shared types and helpers for the ingress    |
// | dispatcher. Rev 1.0                                                   |
// +----------------------------------------------------------------------+
package pkt_ingress_dispatch_pkg;

    localparam int DEF_DATA_W  = 256;
    localparam int DEF_NUM_PRI = 8;
    localparam int DEF_PRI_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    function automatic logic [DEF_NUM_PRI-1:0] pri_onehot(input logic [DEF_PRI_W-1:0] pri);
        logic [DEF_NUM_PRI-1:0] oh;
        oh      = '0;
        oh[pri] = 1'b1;
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_ingress_dispatch_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sat_counter: statistics counter that sticks at all-ones. Rev 1.0      |
// +----------------------------------------------------------------------+
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pkt_ingress_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_ingress_dispatch: steers whole packets to per-priority FIFOs,     |
// | enforcing framing and dropping into full queues. Rev 1.0              |
// +----------------------------------------------------------------------+
module pkt_ingress_dispatch
    import pkt_ingress_dispatch_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_PRI   = DEF_NUM_PRI,
    parameter int PRI_W     = DEF_PRI_W,
    parameter int PRI_LSB   = 0,
    parameter int MAX_BEATS = 64,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_sop,
    input  logic               in_eop,
    input  logic               in_vld,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [NUM_PRI-1:0] q_full,
    output logic [NUM_PRI-1:0] q_wr_vld,
    output logic               q_wr_sop,
    output logic               q_wr_eop,
    output logic [DATA_W-1:0]  q_wr_data,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               busy
);

    localparam int BCW = $clog2(MAX_BEATS) + 1;

    state_e             state_q, state_d;
    logic [PRI_W-1:0]   cur_pri_q, cur_pri_d;
    logic [BCW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [NUM_PRI-1:0] wr_vld_q, wr_vld_d;
    logic               wr_sop_q, wr_sop_d;
    logic               wr_eop_q, wr_eop_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               drop_inc, err_inc;

    logic [PRI_W-1:0]   w_hdr_pri;
    logic               w_hdr_full;
    logic [BCW-1:0]     w_cnt_inc;
    logic               w_at_max;

    assign w_hdr_pri  = in_data[PRI_LSB +: PRI_W];
    assign w_hdr_full = q_full[w_hdr_pri];
    assign w_cnt_inc  = beat_cnt_q + 1'b1;
    assign w_at_max   = (w_cnt_inc == BCW'(MAX_BEATS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_pri_q  <= '0;
            beat_cnt_q <= '0;
            wr_vld_q   <= '0;
            wr_sop_q   <= 1'b0;
            wr_eop_q   <= 1'b0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_pri_q  <= cur_pri_d;
            beat_cnt_q <= beat_cnt_d;
            wr_vld_q   <= wr_vld_d;
            wr_sop_q   <= wr_sop_d;
            wr_eop_q   <= wr_eop_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // A sop seen in DROP is handled exactly like one seen in IDLE.
    always_comb begin
        state_d    = state_q;
        cur_pri_d  = cur_pri_q;
        beat_cnt_d = beat_cnt_q;
        if (in_vld) begin
            case (state_q)
                ST_FWD: begin
                    if (in_sop) begin
                        state_d = in_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        beat_cnt_d = w_cnt_inc;
                        if (in_eop)        state_d = ST_IDLE;
                        else if (w_at_max) state_d = ST_DROP;
                    end
                end
                default: begin
                    if (in_sop) begin
                        if (w_hdr_full) begin
                            state_d = in_eop ? ST_IDLE : ST_DROP;
                        end else begin
                            cur_pri_d  = w_hdr_pri;
                            beat_cnt_d = BCW'(1);
                            state_d    = in_eop ? ST_IDLE : ST_FWD;
                        end
                    end else if ((state_q == ST_DROP) && in_eop) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        wr_vld_d  = '0;
        wr_sop_d  = 1'b0;
        wr_eop_d  = 1'b0;
        wr_data_d = '0;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;
        if (in_vld) begin
            case (state_q)
                ST_FWD: begin
                    wr_vld_d  = pri_onehot(cur_pri_q);
                    wr_data_d = in_data;
                    if (in_sop) begin
                        wr_eop_d = 1'b1;
                        err_inc  = 1'b1;
                    end else begin
                        wr_eop_d = in_eop | w_at_max;
                        err_inc  = ~in_eop & w_at_max;
                    end
                end
                default: begin
                    if (in_sop) begin
                        if (w_hdr_full) begin
                            drop_inc = 1'b1;
                        end else begin
                            wr_vld_d  = pri_onehot(w_hdr_pri);
                            wr_sop_d  = 1'b1;
                            wr_eop_d  = in_eop;
                            wr_data_d = in_data;
                        end
                    end else if (state_q == ST_IDLE) begin
                        err_inc = 1'b1;
                    end
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .cnt_o (drop_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .cnt_o (err_cnt)
    );

    assign q_wr_vld  = wr_vld_q;
    assign q_wr_sop  = wr_sop_q;
    assign q_wr_eop  = wr_eop_q;
    assign q_wr_data = wr_data_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire
